// File: rtl/set_pkg.sv
// set_pkg: shared widths, mode encodings, FSM states and request payload
// layout for the SET query controller.
package set_pkg;

    localparam int CENTRAL_W = 24;   // {x1,y1,x2,y2,x3,y3}, 4 bits each
    localparam int RADIUS_W  = 12;   // {r1,r2,r3}
    localparam int MODE_W    = 2;
    localparam int CAND_W    = 8;    // count 0..64

    // Set-operation modes; the controller passes them through untouched.
    localparam logic [MODE_W-1:0] MODE_A       = 2'd0;
    localparam logic [MODE_W-1:0] MODE_A_AND_B = 2'd1;
    localparam logic [MODE_W-1:0] MODE_A_XOR_B = 2'd2;
    localparam logic [MODE_W-1:0] MODE_TWO_OF3 = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    // Request payload; the sequence tag is appended below it in the FIFO.
    typedef struct packed {
        logic [CENTRAL_W-1:0] central;
        logic [RADIUS_W-1:0]  radius;
        logic [MODE_W-1:0]    mode;
    } set_job_t;

    localparam int JOB_W = $bits(set_job_t);

endpackage

// File: rtl/set_req_fifo.sv
// set_req_fifo: synchronous DEPTH-entry request FIFO with wrap-around
// pointers (extra MSB distinguishes full from empty). Head is read
// combinationally so the controller can present it in the issue cycle.
module set_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 42
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Fullness is pre-pop: a push into a full FIFO waits even if it pops.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Storage array, written at the tail.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

    // Pointer advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/set_query_ctrl.sv
// set_query_ctrl: buffers tagged SET query requests, issues them to the
// engine only at sync points (set_valid or !set_busy), and returns each
// captured count tagged, in request order, through a response register
// backed by a one-deep skid.
// Optional build macro SET_QCTRL_TIMEOUT_EN adds a sticky watchdog.
module set_query_ctrl
    import set_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [CENTRAL_W-1:0] req_central,
    input  logic [RADIUS_W-1:0]  req_radius,
    input  logic [MODE_W-1:0]    req_mode,
    output logic [TAG_W-1:0]     req_tag,
    output logic                 set_en,
    output logic [CENTRAL_W-1:0] set_central,
    output logic [RADIUS_W-1:0]  set_radius,
    output logic [MODE_W-1:0]    set_mode,
    input  logic                 set_busy,
    input  logic                 set_valid,
    input  logic [CAND_W-1:0]    set_candidate,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [CAND_W-1:0]    rsp_candidate,
    output logic [TAG_W-1:0]     rsp_tag,
    output logic                 err_timeout
);

    localparam int ENTRY_W = JOB_W + TAG_W;

    state_e             state_q;
    logic [TAG_W-1:0]   tag_q, tag_d, inflight_tag_q, head_tag;
    set_job_t           job_q, head_job, req_job;
    logic [ENTRY_W-1:0] fifo_wdata, fifo_rdata;
    logic               fifo_full, fifo_empty, push;
    logic               sync_pt, rsp_free, capture;
    logic               issue_first, issue_b2b, timeout_hit;

    logic               rsp_valid_q, skid_valid_q;
    logic [CAND_W-1:0]  rsp_cand_q, skid_cand_q;
    logic [TAG_W-1:0]   rsp_tag_q, skid_tag_q;

    // ---------------- request side ----------------
    assign req_job    = '{central: req_central, radius: req_radius, mode: req_mode};
    assign fifo_wdata = {req_job, tag_q};
    assign push       = req_valid && !fifo_full;
    assign req_ready  = !fifo_full;
    assign req_tag    = tag_q;
    assign tag_d      = tag_q + 1'b1;

    set_req_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (fifo_wdata),
        .pop_i   (set_en),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head_job = fifo_rdata[ENTRY_W-1:TAG_W];
    assign head_tag = fifo_rdata[TAG_W-1:0];

    // Sequence tag assigned to each accepted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       tag_q <= '0;
        else if (push) tag_q <= tag_d;
    end

    // ---------------- issue decode ----------------
    // set_en must land in the very cycle the engine reports a sync point,
    // so it is decoded from live engine status rather than registered.
    assign sync_pt     = set_valid || !set_busy;
    assign rsp_free    = !rsp_valid_q || rsp_ready;
    assign capture     = (state_q == WAIT) && set_valid;
    assign issue_first = (state_q == ISSUE) && sync_pt && !fifo_empty && !skid_valid_q;
    // Chain the next job only if this result lands in the response register;
    // otherwise it goes to the skid and the engine is left parked.
    assign issue_b2b   = capture && !fifo_empty && rsp_free;
    assign set_en      = issue_first || issue_b2b;

    // Engine inputs show the entry being issued during set_en, then hold it.
    assign set_central = set_en ? head_job.central : job_q.central;
    assign set_radius  = set_en ? head_job.radius  : job_q.radius;
    assign set_mode    = set_en ? head_job.mode    : job_q.mode;

    assign rsp_valid     = rsp_valid_q;
    assign rsp_candidate = rsp_cand_q;
    assign rsp_tag       = rsp_tag_q;

    // Control FSM plus held engine inputs, response register and skid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            job_q          <= '0;
            inflight_tag_q <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_cand_q     <= '0;
            rsp_tag_q      <= '0;
            skid_valid_q   <= 1'b0;
            skid_cand_q    <= '0;
            skid_tag_q     <= '0;
        end else begin
            if (set_en) begin
                job_q          <= head_job;
                inflight_tag_q <= head_tag;
            end

            // A job is only in flight with the skid empty, so a capture
            // always has somewhere to go.
            if (capture) begin
                if (rsp_free) begin
                    rsp_valid_q <= 1'b1;
                    rsp_cand_q  <= set_candidate;
                    rsp_tag_q   <= inflight_tag_q;
                end else begin
                    skid_valid_q <= 1'b1;
                    skid_cand_q  <= set_candidate;
                    skid_tag_q   <= inflight_tag_q;
                end
            end else if (rsp_valid_q && rsp_ready) begin
                if (skid_valid_q) begin
                    rsp_cand_q   <= skid_cand_q;
                    rsp_tag_q    <= skid_tag_q;
                    skid_valid_q <= 1'b0;
                end else begin
                    rsp_valid_q <= 1'b0;
                end
            end

            case (state_q)
                IDLE:    if (!fifo_empty) state_q <= ISSUE;
                ISSUE:   if (set_en) state_q <= WAIT;
                WAIT: begin
                    if (timeout_hit)                state_q <= IDLE;
                    else if (capture && !issue_b2b) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SET_QCTRL_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [TO_W-1:0] to_cnt_q;
    logic            err_q;

    // Fires so that err_timeout is visible TIMEOUT cycles after set_en.
    assign timeout_hit = (state_q == WAIT) && !set_valid &&
                         (to_cnt_q == TO_W'(TIMEOUT - 2));
    assign err_timeout = err_q;

    // Watchdog: restart at each issue, count WAIT cycles, sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (set_en)                              to_cnt_q <= '0;
            else if (state_q == WAIT && !set_valid)  to_cnt_q <= to_cnt_q + 1'b1;
            if (timeout_hit) err_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_set_query_ctrl.sv
// tb_set_query_ctrl: scoreboard bench for set_query_ctrl with a behavioural
// SET engine (8-cycle/9-cycle latency, optional free-run, dummy pulses, stall).
module tb_set_query_ctrl;

    localparam int DEPTH   = 4;
    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid, req_ready;
    logic [23:0]      req_central;
    logic [11:0]      req_radius;
    logic [1:0]       req_mode;
    logic [TAG_W-1:0] req_tag;
    logic             set_en;
    logic [23:0]      set_central;
    logic [11:0]      set_radius;
    logic [1:0]       set_mode;
    logic             set_busy, set_valid;
    logic [7:0]       set_candidate;
    logic             rsp_valid, rsp_ready;
    logic [7:0]       rsp_candidate;
    logic [TAG_W-1:0] rsp_tag;
    logic             err_timeout;

    always #5 clk = ~clk;

    set_query_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_central(req_central),
        .req_radius(req_radius), .req_mode(req_mode), .req_tag(req_tag),
        .set_en(set_en), .set_central(set_central), .set_radius(set_radius),
        .set_mode(set_mode), .set_busy(set_busy), .set_valid(set_valid),
        .set_candidate(set_candidate),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_candidate(rsp_candidate),
        .rsp_tag(rsp_tag), .err_timeout(err_timeout)
    );

    // ---------------- checking ----------------
    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference count ----------------
    function automatic bit in_c(input int x, input int y, input int cx, input int cy, input int r);
        return ((x - cx) * (x - cx) + (y - cy) * (y - cy)) <= r * r;
    endfunction

    function automatic logic [7:0] ref_count(input logic [23:0] c, input logic [11:0] r,
                                             input logic [1:0] m);
        int n = 0;
        bit a, b, d;
        for (int x = 1; x <= 8; x++) begin
            for (int y = 1; y <= 8; y++) begin
                a = in_c(x, y, int'(c[23:20]), int'(c[19:16]), int'(r[11:8]));
                b = in_c(x, y, int'(c[15:12]), int'(c[11:8]),  int'(r[7:4]));
                d = in_c(x, y, int'(c[7:4]),   int'(c[3:0]),   int'(r[3:0]));
                case (m)
                    2'd0:    n += int'(a);
                    2'd1:    n += int'(a && b);
                    2'd2:    n += int'(a ^ b);
                    default: n += int'((int'(a) + int'(b) + int'(d)) == 2);
                endcase
            end
        end
        return 8'(n);
    endfunction

    // ---------------- engine model ----------------
    int   dly = 0;
    logic [7:0] eng_cnt = 8'd0;
    bit   free_run = 0, stall = 0, dummy_v = 0;

    always @(posedge clk) begin
        if (set_en) begin
            eng_cnt <= ref_count(set_central, set_radius, set_mode);
            dly     <= set_valid ? 9 : 8;
        end else if (free_run && dly <= 1) begin
            dly <= 9;
        end else if (dly != 0 && !(stall && dly == 2)) begin
            dly <= dly - 1;
        end
    end

    assign set_valid     = (dly == 1 && !stall) || dummy_v;
    assign set_busy      = (dly != 0);
    assign set_candidate = eng_cnt;

    // ---------------- scoreboard / monitor ----------------
    typedef struct { logic [7:0] cand; logic [TAG_W-1:0] tag; } exp_t;
    exp_t sb[$];
    exp_t e;
    logic [TAG_W-1:0] exp_tag = '0;
    int en_cnt, en_idle, en_novalid, rsp_cnt, rsp_seen, acc_cnt, acc_at_full;

    always @(negedge clk) begin
        if (!rst) begin
            if (req_valid && req_ready) begin
                chk("req_tag", req_tag, exp_tag);
                sb.push_back('{ref_count(req_central, req_radius, req_mode), exp_tag});
                exp_tag = exp_tag + 1'b1;
                acc_cnt++;
            end
            if (req_valid && !req_ready && acc_at_full < 0) acc_at_full = acc_cnt;
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) chk("rsp_extra", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("rsp_cand", rsp_candidate, e.cand);
                    chk("rsp_tag", rsp_tag, e.tag);
                end
                rsp_cnt++;
            end
            if (rsp_valid) rsp_seen++;
            if (set_en) begin
                chk("en_sync", set_valid || !set_busy, 1);
                en_cnt++;
                if (!set_busy)  en_idle++;
                if (!set_valid) en_novalid++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clr_cnt();
        en_cnt = 0; en_idle = 0; en_novalid = 0;
        rsp_cnt = 0; rsp_seen = 0; acc_cnt = 0; acc_at_full = -1;
    endtask

    task automatic send(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
        bit ok = 0;
        req_central = c; req_radius = r; req_mode = m; req_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (!ok) chk("req_accept", 0, 1);
    endtask

    task automatic wait_rsp(input int target);
        for (int i = 0; i < 300 && rsp_cnt < target; i++) @(posedge clk);
        #1;
        if (rsp_cnt < target) chk("rsp_wait", rsp_cnt, target);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (set_valid) break;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        exp_tag = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1; req_valid = 1'b0; req_central = '0; req_radius = '0; req_mode = '0;
        rsp_ready = 1'b1;
        clr_cnt();
        repeat (3) @(posedge clk); #1;
        chk("rst_set_en", set_en, 0);
        chk("rst_set_central", set_central, 0);
        chk("rst_set_radius", set_radius, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_cand", rsp_candidate, 0);
        chk("rst_rsp_tag", rsp_tag, 0);
        chk("rst_err", err_timeout, 0);
        rst = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_req_tag", req_tag, 0);

        // T1: single job, idle engine, A=(4,4) r1=15 covers all 64 points
        send({4'd4, 4'd4, 16'h0000}, {4'd15, 8'h00}, 2'd0);
        wait_rsp(1);
        chk("t1_en_cnt", en_cnt, 1);
        chk("t1_en_idle", en_idle, 1);

        // T2: five requests into a 4-deep FIFO, free-running engine
        do_reset();
        free_run = 1;
        clr_cnt();
        wait_valid();
        for (int k = 0; k < 5; k++) send(24'($urandom), 12'($urandom), 2'(k));
        wait_rsp(5);
        chk("t2_full_after", acc_at_full, 4);
        chk("t2_en_cnt", en_cnt, 5);
        chk("t2_en_off_valid", en_novalid, 0);

        // T3: hold responses across three jobs
        rsp_ready = 1'b0;
        clr_cnt();
        wait_valid();
        for (int k = 0; k < 3; k++) send(24'($urandom), 12'($urandom), 2'($urandom));
        repeat (45) @(posedge clk); #1;
        chk("t3_en_held", en_cnt, 2);
        chk("t3_rsp_held", rsp_valid, 1);
        chk("t3_no_xfer", rsp_cnt, 0);
        rsp_ready = 1'b1;
        wait_rsp(3);
        chk("t3_en_total", en_cnt, 3);

        // T4: free-run and dummy pulses with no requests
        clr_cnt();
        repeat (30) @(posedge clk);
        free_run = 0;
        repeat (12) @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            dummy_v = 1; @(posedge clk); #1;
            dummy_v = 0; repeat (2) @(posedge clk); #1;
        end
        chk("t4_no_rsp", rsp_seen, 0);
        chk("t4_no_en", en_cnt, 0);

        // T5: reset while a job is in flight
        clr_cnt();
        send(24'h123456, 12'h789, 2'd1);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (set_en) break;
        end
        repeat (3) @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        exp_tag = '0;
        #1;
        chk("t5_set_en", set_en, 0);
        chk("t5_set_central", set_central, 0);
        chk("t5_set_radius", set_radius, 0);
        chk("t5_set_mode", set_mode, 0);
        chk("t5_rsp_valid", rsp_valid, 0);
        chk("t5_rsp_cand", rsp_candidate, 0);
        chk("t5_rsp_tag", rsp_tag, 0);
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        chk("t5_req_tag0", req_tag, 0);
        repeat (20) @(posedge clk); #1;
        chk("t5_no_stray", rsp_seen, 0);
        send({4'd2, 4'd3, 4'd5, 4'd5, 4'd7, 4'd1}, {4'd3, 4'd4, 4'd2}, 2'd3);
        wait_rsp(1);

`ifdef SET_QCTRL_TIMEOUT_EN
        // T6: engine never answers
        stall = 1;
        clr_cnt();
        send(24'hABCDEF, 12'h321, 2'd2);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (set_en) break;
        end
        repeat (TIMEOUT - 1) @(negedge clk);
        chk("t6_err_early", err_timeout, 0);
        @(negedge clk);
        chk("t6_err", err_timeout, 1);
        if (sb.size() != 0) void'(sb.pop_back());
        stall = 0;
        @(posedge clk); #1;
        send(24'h444400, 12'hF00, 2'd0);
        wait_rsp(1);
        chk("t6_err_sticky", err_timeout, 1);
        chk("t6_rsp_after", rsp_cnt, 1);
`endif

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/set_query_ctrl.md
Name: set_query_ctrl

Overview:
- Initiator/host for the SET circle-membership counting engine.
- Accepts queued query requests (central, radius, mode) over a valid/ready port, buffers them, and drives the engine's en/central/radius/mode inputs at legal issue points.
- Captures the engine's candidate count on set_valid and returns it tagged over a valid/ready response port.
- Sits between a host/bus front end and one SET instance.

Parameters:
DEPTH, 4, request FIFO entries (power of 2, >=2)
TAG_W, 4, width of sequence tag attached to each request/response
TIMEOUT, 32, cycles allowed from set_en to set_valid before error (used only with SET_QCTRL_TIMEOUT_EN)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
req_valid  input  1  request present
req_ready  output  1  request FIFO not full
req_central  input  24  {x1,y1,x2,y2,x3,y3}, 4 bits each
req_radius  input  12  {r1,r2,r3}
req_mode  input  2  set-operation mode, passed through unchanged
req_tag  output  TAG_W  tag that will be assigned if the request is accepted this cycle
set_en  output  1  one-cycle load strobe to the engine
set_central  output  24  held engine input
set_radius  output  12  held engine input
set_mode  output  2  held engine input
set_busy  input  1  engine busy
set_valid  input  1  engine result strobe
set_candidate  input  8  engine count, 0..64
rsp_valid  output  1  response held
rsp_ready  input  1  response consumed
rsp_candidate  output  8  captured count
rsp_tag  output  TAG_W  tag of the originating request
err_timeout  output  1  sticky watchdog error (tied 0 without macro)

Behaviour:
- Reset values:
  - set_en=0; set_central/radius/mode=0.
  - rsp_valid=0, rsp_candidate=0, rsp_tag=0, err_timeout=0.
  - FIFO empty; tag counter=0; state=IDLE.
  - req_ready=1 after reset deasserts.
- Accept: req_valid&req_ready pushes {central,radius,mode,tag}; tag counter increments mod 2^TAG_W.
- Full FIFO drops req_ready; the request is held by the sender, never lost.
- Simultaneous push and pop on a full FIFO is legal; req_ready reflects pre-pop fullness.
- Engine issue point (sync point): a cycle with set_valid==1 or set_busy==0. set_en is asserted only at a sync point.
  - The engine does not restart its row counter on en mid-scan, so en outside a sync point corrupts the count and is forbidden.
- Engine latency: en at a sync point gives set_valid exactly 9 cycles later (en in a set_valid cycle) or 8 cycles later (en in a set_busy==0 cycle).
- The engine free-runs between jobs. Any set_valid not preceded by this block's set_en is a dummy result and is ignored.
- FSM:
  - IDLE: FIFO empty, no job in flight. FIFO non-empty -> ISSUE.
  - ISSUE: drive the head entry onto the set_* registers. At a sync point, pulse set_en, pop FIFO, latch the tag into inflight_tag -> WAIT.
  - WAIT: on set_valid, capture set_candidate/inflight_tag into the response register, assert rsp_valid.
    - Back-to-back: if the FIFO is non-empty in the same cycle, also pulse set_en with the next head entry and pop; stay WAIT.
    - Otherwise -> IDLE.
    - If rsp_valid is already set and not being consumed (rsp_ready==0) when set_valid arrives, hold the job in the engine: do not issue. The captured result moves to a one-deep skid register, so no result is ever lost. With the skid full, no new set_en until drained.
- Response: rsp_valid stays high with stable data until rsp_ready. A response transfer and a new capture in the same cycle are legal; the register reloads without a gap.
- set_* data registers change only at set_en, and hold otherwise.
- Ordering: responses leave in request order; tags are strictly sequential.
- rst mid-operation: everything returns to reset values immediately. The in-flight job is dropped without a response.

Optional Feature:
SET_QCTRL_TIMEOUT_EN
- Defined: a counter starts at set_en. If set_valid does not arrive within TIMEOUT cycles, err_timeout sets sticky (cleared only by rst) and the FSM returns to IDLE. The job is discarded without a response.
- Undefined: no counter; err_timeout is tied 0; WAIT waits indefinitely.

Decomposition:
- Package set_pkg:
  - Widths CENTRAL_W=24, RADIUS_W=12, MODE_W=2, CAND_W=8.
  - Mode encoding constants.
  - FSM state enum {IDLE, ISSUE, WAIT}.
  - Request-entry struct layout.
- Sub-module: set_req_fifo, a synchronous DEPTH x (38+TAG_W) FIFO with full/empty and wrap-around pointers.

Test Plan:
- Reset, then one request mode 0, central A=(4,4), r1=15 -> set_en once, in a set_busy==0 cycle; rsp_candidate=64, rsp_tag=0.
- Push 5 requests with DEPTH=4 and rsp_ready=1 -> req_ready drops after the 4th accept. All 5 responses arrive in order with tags 0..4, back-to-back, with set_en coinciding with set_valid.
- Hold rsp_ready=0 across 3 completed jobs -> no more than 2 results buffered, no extra set_en. Release -> 3 responses with correct counts and no loss.
- Idle engine free-runs for 30 cycles -> no rsp_valid. Dummy set_valid pulses are ignored, and set_en never appears outside a sync point (assertion).
- Assert rst during WAIT -> all outputs return to 0 at once, with no stray response after release. The next request gets tag 0.
- With SET_QCTRL_TIMEOUT_EN and a stub engine that never raises set_valid -> err_timeout=1 at cycle TIMEOUT after set_en, and the FSM returns to IDLE.
